// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator: registered fetch PC, direct-mapped BTB with 2-bit
// direction counters, and mispredict redirect/flush from EX.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        br_valid_E,
    input  logic        br_taken_E,
    input  logic [31:0] br_pc_E,
    input  logic [31:0] br_target_E,
    input  logic        br_mispredict_E,
    input  logic [31:0] br_fix_pc_E,
    output logic [31:0] PCF,
    output logic        pred_taken_F,
    output logic [31:0] pred_target_F,
    output logic        flush_D,
    output logic        flush_E
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 32 - IW - 2;

    logic [31:0]            pcf_q, pcf_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0]          tag_q    [BTB_ENTRIES];
    logic [TW-1:0]          tag_d    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [31:0]            target_d [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [1:0]             ctr_d    [BTB_ENTRIES];

    logic [IW-1:0] idx_f, idx_e;
    logic [TW-1:0] tag_f, tag_e;
    logic          hit_f, hit_e;
    logic [31:0]   pcf_plus4;
    logic [31:0]   next_pc;

    // Address bits below the word offset carry no information here.
    logic unused_bits;
    assign unused_bits = ^{br_pc_E[1:0], br_fix_pc_E[1:0], next_pc[1:0]};

    assign idx_f     = pcf_q[IW+1:2];
    assign tag_f     = pcf_q[31:IW+2];
    assign hit_f     = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pcf_plus4 = pcf_q + 32'd4;

    assign pred_taken_F  = hit_f && ctr_q[idx_f][1];
    assign pred_target_F = pred_taken_F ? target_q[idx_f] : pcf_plus4;

    assign idx_e = br_pc_E[IW+1:2];
    assign tag_e = br_pc_E[31:IW+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign flush_D = br_mispredict_E;
    assign flush_E = br_mispredict_E;
    assign PCF     = pcf_q;

    always_comb begin
        next_pc = pcf_q;
        if (br_mispredict_E) begin
            next_pc = br_fix_pc_E;
        end else if (en) begin
            next_pc = pred_target_F;
        end
        // A stored target may carry low bits; the fetch PC stays word aligned.
        pcf_d = {next_pc[31:2], 2'b00};
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (br_valid_E) begin
            if (hit_e) begin
                if (br_taken_E) begin
                    ctr_d[idx_e]    = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
                    target_d[idx_e] = br_target_E;
                end else begin
                    ctr_d[idx_e]    = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
                end
            end else if (br_taken_E) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = br_target_E;
                ctr_d[idx_e]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q   <= RESET_PC;
            valid_q <= '0;
        end else begin
            pcf_q   <= pcf_d;
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (8-entry BTB, reset PC 0).
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        br_valid_E;
    logic        br_taken_E;
    logic [31:0] br_pc_E;
    logic [31:0] br_target_E;
    logic        br_mispredict_E;
    logic [31:0] br_fix_pc_E;
    logic [31:0] PCF;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic        flush_D;
    logic        flush_E;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit #(.RESET_PC(32'h0), .BTB_ENTRIES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .br_valid_E     (br_valid_E),
        .br_taken_E     (br_taken_E),
        .br_pc_E        (br_pc_E),
        .br_target_E    (br_target_E),
        .br_mispredict_E(br_mispredict_E),
        .br_fix_pc_E    (br_fix_pc_E),
        .PCF            (PCF),
        .pred_taken_F   (pred_taken_F),
        .pred_target_F  (pred_target_F),
        .flush_D        (flush_D),
        .flush_E        (flush_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        br_mispredict_E = 1'b1;
        br_fix_pc_E     = pc;
        step();
        br_mispredict_E = 1'b0;
        #1;
    endtask

    task automatic update(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
        br_valid_E  = 1'b1;
        br_taken_E  = taken;
        br_pc_E     = pc;
        br_target_E = tgt;
        step();
        br_valid_E  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (PCF !== 32'h0) begin
            failures++; $display("FAIL reset_pcf: got %h expected %h", PCF, 32'h0);
        end
        checks++;
        if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h4) begin
            failures++; $display("FAIL reset_pred: got %b/%h expected 0/%h", pred_taken_F, pred_target_F, 32'h4);
        end
        br_mispredict_E = 1'b1;
        #1;
        checks++;
        if (flush_D !== 1'b1 || flush_E !== 1'b1) begin
            failures++; $display("FAIL reset_flush: got %b%b expected 11", flush_D, flush_E);
        end
        br_mispredict_E = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (PCF !== 32'(4 * i)) begin
                failures++; $display("FAIL seq_fetch: got %h expected %h", PCF, 32'(4 * i));
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (PCF !== 32'h0) begin
            failures++; $display("FAIL async_reset: got %h expected %h", PCF, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (PCF !== 32'(4 * i) || pred_taken_F !== 1'b0) begin
                failures++; $display("FAIL post_reset_seq: got %h/%b expected %h/0", PCF, pred_taken_F, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        step();
        en          = 1'b0;
        br_valid_E  = 1'b1;
        br_taken_E  = 1'b1;
        br_pc_E     = 32'h20;
        br_target_E = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            br_valid_E = 1'b0;
            checks++;
            if (PCF !== 32'h10) begin
                failures++; $display("FAIL stall_hold: got %h expected %h", PCF, 32'h10);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (PCF !== 32'h14) begin
            failures++; $display("FAIL stall_release: got %h expected %h", PCF, 32'h14);
        end
    endtask

    task automatic test_alloc_predict();
        step();
        step();
        step();
        checks++;
        if (PCF !== 32'h20 || pred_taken_F !== 1'b1 || pred_target_F !== 32'h100) begin
            failures++; $display("FAIL alloc_predict: got %h/%b/%h expected 20/1/100", PCF, pred_taken_F, pred_target_F);
        end
        step();
        checks++;
        if (PCF !== 32'h100 || pred_taken_F !== 1'b0 || pred_target_F !== 32'h104) begin
            failures++; $display("FAIL follow_target: got %h/%b/%h expected 100/0/104", PCF, pred_taken_F, pred_target_F);
        end
    endtask

    task automatic test_saturation();
        logic        exp_t [7];
        logic [31:0] exp_tg [7];
        logic        tk [7];
        logic [31:0] up_tg [7];
        // ctr: 10 ->01 ->00 ->00 ->01 ->10 ->11 ; then NT ->10
        tk    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        up_tg = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h100, 32'h140, 32'h0};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_tg = '{32'h24, 32'h24, 32'h24, 32'h24, 32'h100, 32'h140, 32'h140};
        en = 1'b0;
        redirect(32'h20);
        checks++;
        if (PCF !== 32'h20 || pred_taken_F !== 1'b1) begin
            failures++; $display("FAIL sat_start: got %h/%b expected 20/1", PCF, pred_taken_F);
        end
        for (int i = 0; i < 7; i++) begin
            update(tk[i], 32'h20, up_tg[i]);
            checks++;
            if (pred_taken_F !== exp_t[i] || pred_target_F !== exp_tg[i]) begin
                failures++; $display("FAIL sat_step%0d: got %b/%h expected %b/%h", i, pred_taken_F, pred_target_F, exp_t[i], exp_tg[i]);
            end
        end
    endtask

    task automatic test_mispredict();
        en              = 1'b0;
        br_mispredict_E = 1'b1;
        br_fix_pc_E     = 32'h203;
        #1;
        checks++;
        if (flush_D !== 1'b1 || flush_E !== 1'b1) begin
            failures++; $display("FAIL mp_flush: got %b%b expected 11", flush_D, flush_E);
        end
        step();
        checks++;
        if (PCF !== 32'h200) begin
            failures++; $display("FAIL mp_redirect: got %h expected %h", PCF, 32'h200);
        end
        br_mispredict_E = 1'b0;
        #1;
        checks++;
        if (flush_D !== 1'b0 || flush_E !== 1'b0) begin
            failures++; $display("FAIL mp_flush_clear: got %b%b expected 00", flush_D, flush_E);
        end
    endtask

    task automatic test_aliasing();
        en              = 1'b0;
        br_mispredict_E = 1'b1;
        br_fix_pc_E     = 32'h40;
        br_valid_E      = 1'b1;
        br_taken_E      = 1'b1;
        br_pc_E         = 32'h40;
        br_target_E     = 32'h300;
        step();
        br_mispredict_E = 1'b0;
        br_valid_E      = 1'b0;
        #1;
        checks++;
        if (PCF !== 32'h40 || pred_taken_F !== 1'b1 || pred_target_F !== 32'h300) begin
            failures++; $display("FAIL alias_new: got %h/%b/%h expected 40/1/300", PCF, pred_taken_F, pred_target_F);
        end
        redirect(32'h20);
        checks++;
        if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h24) begin
            failures++; $display("FAIL alias_evicted: got %b/%h expected 0/24", pred_taken_F, pred_target_F);
        end
        br_valid_E  = 1'b1;
        br_taken_E  = 1'b1;
        br_pc_E     = 32'h20;
        br_target_E = 32'h500;
        #1;
        checks++;
        if (pred_taken_F !== 1'b0) begin
            failures++; $display("FAIL no_bypass: got %b expected 0", pred_taken_F);
        end
        step();
        br_valid_E = 1'b0;
        #1;
        checks++;
        if (pred_taken_F !== 1'b1 || pred_target_F !== 32'h500) begin
            failures++; $display("FAIL realloc: got %b/%h expected 1/500", pred_taken_F, pred_target_F);
        end
        update(1'b0, 32'h40, 32'h0);
        checks++;
        if (pred_taken_F !== 1'b1 || pred_target_F !== 32'h500) begin
            failures++; $display("FAIL miss_nt_nochange: got %b/%h expected 1/500", pred_taken_F, pred_target_F);
        end
        redirect(32'h40);
        checks++;
        if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h44) begin
            failures++; $display("FAIL alias_back: got %b/%h expected 0/44", pred_taken_F, pred_target_F);
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b0;
        redirect(32'hFFFF_FFFC);
        checks++;
        if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h0) begin
            failures++; $display("FAIL wrap_target: got %b/%h expected 0/0", pred_taken_F, pred_target_F);
        end
        en = 1'b1;
        step();
        checks++;
        if (PCF !== 32'h0) begin
            failures++; $display("FAIL wrap_pcf: got %h expected %h", PCF, 32'h0);
        end
        br_valid_E  = 1'b1;
        br_taken_E  = 1'b1;
        br_pc_E     = 32'h60;
        br_target_E = 32'h700;
        #2;
        rst_n = 1'b0;
        step();
        br_valid_E = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (PCF !== 32'h0) begin
            failures++; $display("FAIL midreset_pcf: got %h expected %h", PCF, 32'h0);
        end
        en = 1'b0;
        redirect(32'h60);
        checks++;
        if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h64) begin
            failures++; $display("FAIL midreset_discard: got %b/%h expected 0/64", pred_taken_F, pred_target_F);
        end
        redirect(32'h20);
        checks++;
        if (pred_taken_F !== 1'b0 || pred_target_F !== 32'h24) begin
            failures++; $display("FAIL midreset_cleared: got %b/%h expected 0/24", pred_taken_F, pred_target_F);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        en              = 1'b1;
        br_valid_E      = 1'b0;
        br_taken_E      = 1'b0;
        br_pc_E         = 32'h0;
        br_target_E     = 32'h0;
        br_mispredict_E = 1'b0;
        br_fix_pc_E     = 32'h0;
        test_reset();
        test_stall();
        test_alloc_predict();
        test_saturation();
        test_mispredict();
        test_aliasing();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
